// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: state encodings and stall/flush bit indices for the pipeline hazard controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    CTRL_IDLE  = 2'd0,
    CTRL_PEND  = 2'd1,
    CTRL_FLUSH = 2'd2
  } ctrl_state_e;
  localparam int STALL_PC   = 0;
  localparam int STALL_IFID = 1;
  localparam int STALL_IDEX = 2;
  localparam int STALL_EXMEM = 3;
  localparam int STALL_WB   = 4;
  localparam int FLUSH_IFID = 0;
  localparam int FLUSH_IDEX = 1;
endpackage

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline stall/flush/redirect controller; PIPE_CTRL_PERF_EN adds perf counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] RST_PC       = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_jump_flag_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        id_load_use_i,
  input  logic        if_busy_i,
  input  logic        mem_busy_i,
  output logic [4:0]  ctrl_stall_o,
  output logic [1:0]  ctrl_flush_o,
  output logic        ctrl_jump_flag_o,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0] ctrl_stall_cnt_o,
  output logic [31:0] ctrl_flush_cnt_o,
  output logic [31:0] ctrl_redir_cnt_o,
`endif
  output logic [31:0] ctrl_jump_addr_o
);
  localparam logic [1:0] LAST = 2'(FLUSH_CYCLES - 1);
  localparam logic [4:0] HOLD_FRONT = (5'b1 << STALL_PC) | (5'b1 << STALL_IFID);
  localparam logic [1:0] BUBBLE_EX  = 2'b1 << FLUSH_IDEX;
  localparam logic [1:0] BUBBLE_ID  = 2'b1 << FLUSH_IFID;
  ctrl_state_e r_state, w_next;
  logic [1:0]  r_cnt, w_cnt_next;
  logic [31:0] r_target, w_target_next, w_addr;
  logic [4:0]  w_stall;
  logic [1:0]  w_flush;
  logic        w_jump, w_same;
  ctrl_state_e w_issue_state;
  assign w_issue_state = (LAST == 2'd0) ? CTRL_IDLE : CTRL_FLUSH;
  always_comb begin
    w_stall       = '0;
    w_flush       = '0;
    w_jump        = 1'b0;
    w_same        = 1'b0;
    w_next        = r_state;
    w_cnt_next    = r_cnt;
    w_target_next = r_target;
    if (mem_busy_i) begin
      w_stall = '1;
      if (r_state == CTRL_IDLE && ex_jump_flag_i) begin
        w_next        = CTRL_PEND;
        w_target_next = ex_jump_addr_i;
      end
    end else begin
      case (r_state)
        CTRL_IDLE: begin
          if (ex_jump_flag_i) begin
            w_target_next = ex_jump_addr_i;
            w_jump        = !if_busy_i;
            w_same        = !if_busy_i;
            w_stall       = if_busy_i ? HOLD_FRONT : '0;
            w_flush       = if_busy_i ? BUBBLE_EX : 2'b11;
            w_next        = if_busy_i ? CTRL_PEND : w_issue_state;
            w_cnt_next    = if_busy_i ? r_cnt : LAST;
          end else if (id_load_use_i) begin
            w_stall = HOLD_FRONT;
            w_flush = BUBBLE_EX;
          end else if (if_busy_i) begin
            w_stall = HOLD_FRONT;
            w_flush = BUBBLE_ID;
          end
        end
        CTRL_PEND: begin
          // keep EX empty while waiting so the resolved branch never re-executes
          w_stall    = if_busy_i ? HOLD_FRONT : '0;
          w_flush    = if_busy_i ? BUBBLE_EX : 2'b11;
          w_jump     = !if_busy_i;
          w_next     = if_busy_i ? CTRL_PEND : w_issue_state;
          w_cnt_next = if_busy_i ? r_cnt : LAST;
        end
        CTRL_FLUSH: begin
          w_stall    = if_busy_i ? HOLD_FRONT : '0;
          w_flush    = 2'b11;
          w_next     = (r_cnt <= 2'd1) ? CTRL_IDLE : CTRL_FLUSH;
          w_cnt_next = (r_cnt == 2'd0) ? 2'd0 : r_cnt - 2'd1;
        end
        default: w_next = CTRL_IDLE;
      endcase
    end
  end
  assign w_addr           = w_same ? ex_jump_addr_i : r_target;
  assign ctrl_stall_o     = rst ? '0 : w_stall;
  assign ctrl_flush_o     = rst ? '0 : w_flush;
  assign ctrl_jump_flag_o = !rst && w_jump;
  assign ctrl_jump_addr_o = rst ? RST_PC : {w_addr[31:1], 1'b0};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= CTRL_IDLE;
      r_cnt    <= '0;
      r_target <= RST_PC;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt_next;
      r_target <= w_target_next;
    end
  end
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cnt, r_flush_cnt, r_redir_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_redir_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + 32'(ctrl_stall_o[STALL_PC]);
      r_flush_cnt <= r_flush_cnt + 32'(|ctrl_flush_o);
      r_redir_cnt <= r_redir_cnt + 32'(ctrl_jump_flag_o);
    end
  end
  assign ctrl_stall_cnt_o = r_stall_cnt;
  assign ctrl_flush_cnt_o = r_flush_cnt;
  assign ctrl_redir_cnt_o = r_redir_cnt;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;
  typedef struct {
    string       tag;
    logic [4:0]  st;
    logic [1:0]  fl;
    logic        jf;
    logic [31:0] ja;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_jump_flag_i = 1'b0;
  logic [31:0] ex_jump_addr_i = '0;
  logic        id_load_use_i = 1'b0;
  logic        if_busy_i = 1'b0;
  logic        mem_busy_i = 1'b0;
  logic [4:0]  ctrl_stall_o;
  logic [1:0]  ctrl_flush_o;
  logic        ctrl_jump_flag_o;
  logic [31:0] ctrl_jump_addr_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] ctrl_stall_cnt_o, ctrl_flush_cnt_o, ctrl_redir_cnt_o;
`endif
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  pipe_ctrl #(.RST_PC(32'h0000_0000), .FLUSH_CYCLES(2)) dut (
    .clk(clk),
    .rst(rst),
    .ex_jump_flag_i(ex_jump_flag_i),
    .ex_jump_addr_i(ex_jump_addr_i),
    .id_load_use_i(id_load_use_i),
    .if_busy_i(if_busy_i),
    .mem_busy_i(mem_busy_i),
    .ctrl_stall_o(ctrl_stall_o),
    .ctrl_flush_o(ctrl_flush_o),
    .ctrl_jump_flag_o(ctrl_jump_flag_o),
`ifdef PIPE_CTRL_PERF_EN
    .ctrl_stall_cnt_o(ctrl_stall_cnt_o),
    .ctrl_flush_cnt_o(ctrl_flush_cnt_o),
    .ctrl_redir_cnt_o(ctrl_redir_cnt_o),
`endif
    .ctrl_jump_addr_o(ctrl_jump_addr_o)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, act, exp);
    end
  endtask
  task automatic step(input string tag, input logic r, input logic j, input logic [31:0] a,
                      input logic lu, input logic ib, input logic mb,
                      input logic [4:0] st, input logic [1:0] fl, input logic jf, input logic [31:0] ja);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ex_jump_flag_i = j; ex_jump_addr_i = a;
    id_load_use_i = lu; if_busy_i = ib; mem_busy_i = mb;
    e.tag = tag; e.st = st; e.fl = fl; e.jf = jf; e.ja = ja;
    q.push_back(e);
    @(negedge clk);
    e = q.pop_front();
    chk({e.tag, ".stall"}, 32'(ctrl_stall_o), 32'(e.st));
    chk({e.tag, ".flush"}, 32'(ctrl_flush_o), 32'(e.fl));
    chk({e.tag, ".jflag"}, 32'(ctrl_jump_flag_o), 32'(e.jf));
    chk({e.tag, ".jaddr"}, ctrl_jump_addr_o, e.ja);
  endtask
  initial begin
    //   tag         rst j  addr          lu ib mb   stall     flush  jf  jaddr
    step("rst0",     1, 1, 32'h0000_0055, 0, 0, 0, 5'b00000, 2'b00, 0, 32'h0000_0000);
    step("rst1",     1, 1, 32'h0000_0055, 0, 0, 0, 5'b00000, 2'b00, 0, 32'h0000_0000);
    step("idle",     0, 0, 32'h0,         0, 0, 0, 5'b00000, 2'b00, 0, 32'h0000_0000);
    step("br_issue", 0, 1, 32'h0000_0104, 0, 0, 0, 5'b00000, 2'b11, 1, 32'h0000_0104);
    step("br_fl1",   0, 0, 32'h0,         0, 0, 0, 5'b00000, 2'b11, 0, 32'h0000_0104);
    step("br_idle",  0, 0, 32'h0,         0, 0, 0, 5'b00000, 2'b00, 0, 32'h0000_0104);
    step("ifb_cap",  0, 1, 32'h0000_0200, 0, 1, 0, 5'b00011, 2'b10, 0, 32'h0000_0104);
    step("ifb_p1",   0, 0, 32'h0,         0, 1, 0, 5'b00011, 2'b10, 0, 32'h0000_0200);
    step("ifb_p2",   0, 0, 32'h0,         0, 1, 0, 5'b00011, 2'b10, 0, 32'h0000_0200);
    step("ifb_iss",  0, 0, 32'h0,         0, 0, 0, 5'b00000, 2'b11, 1, 32'h0000_0200);
    step("ifb_fl1",  0, 0, 32'h0,         0, 0, 0, 5'b00000, 2'b11, 0, 32'h0000_0200);
    step("ifb_idle", 0, 0, 32'h0,         0, 0, 0, 5'b00000, 2'b00, 0, 32'h0000_0200);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_stall", ctrl_stall_cnt_o, 32'd3);
    chk("perf_redir", ctrl_redir_cnt_o, 32'd2);
`endif
    step("mem_cap",  0, 1, 32'h0000_0300, 0, 0, 1, 5'b11111, 2'b00, 0, 32'h0000_0200);
    step("mem_hold", 0, 1, 32'h0000_0300, 0, 0, 1, 5'b11111, 2'b00, 0, 32'h0000_0300);
    step("mem_iss",  0, 0, 32'h0,         0, 0, 0, 5'b00000, 2'b11, 1, 32'h0000_0300);
    step("mem_fl1",  0, 0, 32'h0,         0, 0, 0, 5'b00000, 2'b11, 0, 32'h0000_0300);
    step("mem_idle", 0, 0, 32'h0,         0, 0, 0, 5'b00000, 2'b00, 0, 32'h0000_0300);
    step("lu",       0, 0, 32'h0,         1, 0, 0, 5'b00011, 2'b10, 0, 32'h0000_0300);
    step("lu_after", 0, 0, 32'h0,         0, 0, 0, 5'b00000, 2'b00, 0, 32'h0000_0300);
    step("ifb_only", 0, 0, 32'h0,         0, 1, 0, 5'b00011, 2'b01, 0, 32'h0000_0300);
    step("jalr",     0, 1, 32'h0000_0123, 0, 0, 0, 5'b00000, 2'b11, 1, 32'h0000_0122);
    step("jalr_fl",  0, 0, 32'h0,         0, 0, 0, 5'b00000, 2'b11, 0, 32'h0000_0122);
    step("jalr_idl", 0, 0, 32'h0,         0, 0, 0, 5'b00000, 2'b00, 0, 32'h0000_0122);
    step("rp_cap",   0, 1, 32'h0000_0400, 0, 1, 0, 5'b00011, 2'b10, 0, 32'h0000_0122);
    step("rp_rst",   1, 0, 32'h0,         0, 0, 0, 5'b00000, 2'b00, 0, 32'h0000_0000);
    step("rp_after", 0, 0, 32'h0,         0, 0, 0, 5'b00000, 2'b00, 0, 32'h0000_0000);
    step("rp_after2",0, 0, 32'h0,         0, 0, 0, 5'b00000, 2'b00, 0, 32'h0000_0000);
    step("fl_iss",   0, 1, 32'h0000_0500, 0, 0, 0, 5'b00000, 2'b11, 1, 32'h0000_0500);
    step("fl_ign",   0, 1, 32'h0000_0600, 0, 0, 0, 5'b00000, 2'b11, 0, 32'h0000_0500);
    step("fl_idle",  0, 0, 32'h0,         0, 0, 0, 5'b00000, 2'b00, 0, 32'h0000_0500);
    step("pd_cap",   0, 1, 32'h0000_0700, 0, 1, 0, 5'b00011, 2'b10, 0, 32'h0000_0500);
    step("pd_ign",   0, 1, 32'h0000_0800, 0, 1, 0, 5'b00011, 2'b10, 0, 32'h0000_0700);
    step("pd_iss",   0, 0, 32'h0,         0, 0, 0, 5'b00000, 2'b11, 1, 32'h0000_0700);
    step("pd_fl1",   0, 0, 32'h0,         0, 0, 0, 5'b00000, 2'b11, 0, 32'h0000_0700);
    step("pd_idle",  0, 0, 32'h0,         0, 0, 0, 5'b00000, 2'b00, 0, 32'h0000_0700);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
